// File: rtl/hilo_mdu.sv
// hilo_mdu: multicycle multiply sequencer + HI/LO pair; commits LATENCY cycles after accept, busy stalls the pipe.
// Latency: LATENCY edges accept->commit; backpressure: start ignored while busy, mthi/mtlo dropped while busy.
// Optional MDU_SIGNED_EN: signed mult via magnitude conversion and result negation; undefined = multu only.
module hilo_mdu #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_c,
   input  logic               hi_we,
   input  logic               lo_we,
   input  logic [WIDTH-1:0]   wdata,
   output logic               busy,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt;
   logic               accept, commit;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] product;

`ifdef MDU_SIGNED_EN
   logic neg;

   assign a_mag   = (sign && a[WIDTH-1]) ? ('0 - a) : a;
   assign b_mag   = (sign && b[WIDTH-1]) ? ('0 - b) : b;
   assign product = neg ? ('0 - mul_c) : mul_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg <= 1'b0;
      end else if (accept) begin
         neg <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
   end
`else
   logic unused_sign;

   assign unused_sign = sign;
   assign a_mag       = a;
   assign b_mag       = b;
   assign product     = mul_c;
`endif

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // mul_c has had LATENCY cycles to settle from mul_a/mul_b
            if (cnt == 4'(LATENCY - 1)) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         mul_a <= '0;
         mul_b <= '0;
      end else if (accept) begin
         cnt   <= '0;
         mul_a <= a_mag;
         mul_b <= b_mag;
      end else if (state == BUSY) begin
         cnt   <= cnt + 4'd1;
      end
   end

   // mthi/mtlo land only while idle; a start on the same edge commits over them later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         {hi, lo} <= product;
      end else if (state == IDLE) begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

   assign busy = (state == BUSY);

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu (WIDTH 32, LATENCY 3) with a behavioural mulu array on mul_a/mul_b.
module tb_hilo_mdu;
   localparam int W   = 32;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           sign = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_c;
   logic           hi_we = 1'b0;
   logic           lo_we = 1'b0;
   logic [W-1:0]   wdata = '0;
   logic           busy;
   logic [W-1:0]   hi, lo;

   int tests = 0;
   int failed = 0;

   hilo_mdu #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
   );

   assign mul_c = 64'(mul_a) * 64'(mul_b);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mul_run(input string tag, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_ma, input logic [W-1:0] exp_mb,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      start = 1'b1; sign = s; a = av; b = bv;
      tick();
      start = 1'b0;
      chk({tag, " mul_a"}, 64'(mul_a), 64'(exp_ma));
      chk({tag, " mul_b"}, 64'(mul_b), 64'(exp_mb));
      for (int i = 0; i < LAT; i++) begin
         chk({tag, " busy"}, 64'(busy), 64'd1);
         tick();
      end
      chk({tag, " busy done"}, 64'(busy), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      #12;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset mul_a", 64'(mul_a), 64'd0);
      rst_n = 1'b1;
      tick();

      mul_run("u9x12", 1'b0, 32'd9, 32'd12, 32'd9, 32'd12, 32'h0, 32'h6C);
`ifdef MDU_SIGNED_EN
      mul_run("s-6x5", 1'b1, 32'hFFFFFFFA, 32'd5, 32'd6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFE2);
`else
      mul_run("s-6x5", 1'b1, 32'hFFFFFFFA, 32'd5, 32'hFFFFFFFA, 32'd5, 32'h00000004, 32'hFFFFFFE2);
`endif
      mul_run("smin2", 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
      mul_run("umax2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);

      // idle writes: both strobes, then mthi alone
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
      tick();
      chk("mthi+mtlo hi", 64'(hi), 64'hAA);
      chk("mthi+mtlo lo", 64'(lo), 64'hAA);
      lo_we = 1'b0; wdata = 32'h1234;
      tick();
      hi_we = 1'b0;
      chk("mthi hi", 64'(hi), 64'h1234);
      chk("mthi lo kept", 64'(lo), 64'hAA);

      // start 2x3 together with mtlo 0x55
      start = 1'b1; sign = 1'b0; a = 32'd2; b = 32'd3; lo_we = 1'b1; wdata = 32'h55;
      tick();
      lo_we = 1'b0;
      chk("haz lo E0", 64'(lo), 64'h55);
      chk("haz busy E0", 64'(busy), 64'd1);
      // second start and mthi while busy, held through the commit edge
      a = 32'd100; b = 32'd100; hi_we = 1'b1; wdata = 32'hDEAD;
      tick();
      chk("haz lo E1", 64'(lo), 64'h55);
      chk("haz hi E1", 64'(hi), 64'h1234);
      chk("haz mul_a E1", 64'(mul_a), 64'd2);
      tick();
      chk("haz lo E2", 64'(lo), 64'h55);
      chk("haz busy E2", 64'(busy), 64'd1);
      start = 1'b0;
      tick();
      hi_we = 1'b0;
      chk("haz busy E3", 64'(busy), 64'd0);
      chk("haz lo E3", 64'(lo), 64'd6);
      chk("haz hi E3", 64'(hi), 64'd0);
      tick();
      chk("haz no restart", 64'(busy), 64'd0);
      chk("haz mul_a held", 64'(mul_a), 64'd2);
      chk("haz mul_b held", 64'(mul_b), 64'd3);

      // back-to-back issue right after a commit
      mul_run("b2b1", 1'b0, 32'd4, 32'd5, 32'd4, 32'd5, 32'h0, 32'd20);
      mul_run("b2b2", 1'b0, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h1, 32'h0);

      // reset in the middle of a 7x7 multiply
      start = 1'b1; a = 32'd7; b = 32'd7; hi_we = 1'b1; wdata = 32'h77;
      tick();
      start = 1'b0; hi_we = 1'b0;
      chk("rst pre hi", 64'(hi), 64'h77);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst hi", 64'(hi), 64'd0);
      chk("rst lo", 64'(lo), 64'd0);
      chk("rst mul_a", 64'(mul_a), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < LAT + 2; i++) tick();
      chk("rst post busy", 64'(busy), 64'd0);
      chk("rst post hi", 64'(hi), 64'd0);
      chk("rst post lo", 64'(lo), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
